fir_tap_sequencer: RTL and testbench

Time-multiplexed tap scheduler for the band-pass FIR datapath. It accepts one input sample per ready/valid handshake and writes it into the circular delay-line RAM. It then drives a single shared MAC through all NUM_TAPS sample/coefficient address pairs, waits out the MAC pipeline, and presents the captured result on a ready/valid output with backpressure. It sits between the upstream sample source and the delay-line, coefficient ROM, MAC and output register.

---
 rtl/fir_tap_sequencer.sv | 118 +++++++++++
 tb/tb_fir_tap_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_sequencer.sv
// Tap scheduler: one sample in, NUM_TAPS MAC cycles, pipeline drain, held result.
// Define FIR_SEQ_PERF_EN to add sample_count and stall_count outputs.
module fir_tap_sequencer #(
  parameter  int NUM_TAPS    = 16,
  parameter  int MAC_LATENCY = 2,
  localparam int ADDR_W      = $clog2(NUM_TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sample_we,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              mac_en,
  output logic              mac_clear,
  output logic              acc_capture,
  output logic              busy
`ifdef FIR_SEQ_PERF_EN
  ,
  output logic [15:0]       sample_count,
  output logic [15:0]       stall_count
`endif
);

  localparam int DW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(NUM_TAPS - 1);
  localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);
  localparam logic [DW-1:0]     D_LAST = DW'(MAC_LATENCY - 1);
  localparam logic [DW-1:0]     D_ONE  = DW'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    HOLD
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] k;
  logic [ADDR_W-1:0] base;
  logic [DW-1:0]     d;
  logic              armed;
  logic              accept;

  // armed keeps in_ready low until the first edge after reset release
  assign in_ready    = armed && (state == IDLE);
  assign accept      = in_valid & in_ready;
  assign sample_we   = accept;
  assign busy        = (state != IDLE);
  assign mac_en      = (state == RUN);
  assign mac_clear   = mac_en && (k == '0);
  assign coef_addr   = k;
  assign rd_addr     = base - k;
  assign acc_capture = (state == DRAIN) && (d == D_LAST);
  assign out_valid   = (state == HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      k      <= '0;
      d      <= '0;
      base   <= '0;
      wr_ptr <= '0;
      armed  <= 1'b0;
    end else begin
      armed <= 1'b1;
      unique case (state)
        IDLE: begin
          if (accept) begin
            base   <= wr_ptr;
            wr_ptr <= wr_ptr + A_ONE;
            k      <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (k == K_LAST) begin
            d     <= '0;
            state <= DRAIN;
          end else begin
            k <= k + A_ONE;
          end
        end
        DRAIN: begin
          if (d == D_LAST) state <= HOLD;
          else             d     <= d + D_ONE;
        end
        HOLD: begin
          if (out_ready) begin
            k     <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIR_SEQ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_count <= '0;
      stall_count  <= '0;
    end else begin
      if (out_valid && out_ready)
        sample_count <= sample_count + 16'd1;
      if (out_valid && !out_ready && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer (NUM_TAPS=4, MAC_LATENCY=2) against a
// cycle-timeline reference model of each transaction.
module tb_fir_tap_sequencer;

  localparam int N  = 4;
  localparam int ML = 2;
  localparam int AW = 2;
  localparam int HS = N + ML + 1;

  typedef struct packed {
    logic          in_ready;
    logic          busy;
    logic          mac_en;
    logic          mac_clear;
    logic          acc;
    logic          ov;
    logic          we;
    logic [AW-1:0] wp;
    logic [AW-1:0] rd;
    logic [AW-1:0] coef;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          sample_we;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] coef_addr;
  logic          mac_en;
  logic          mac_clear;
  logic          acc_capture;
  logic          busy;
`ifdef FIR_SEQ_PERF_EN
  logic [15:0]   sample_count;
  logic [15:0]   stall_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int wexp     = 0;
  int stall_exp = 0;
  int samp_exp = 0;
  int cyc      = 0;
  int accept_cyc = 0;

  fir_tap_sequencer #(
    .NUM_TAPS(N),
    .MAC_LATENCY(ML)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sample_we(sample_we),
    .wr_ptr(wr_ptr),
    .rd_addr(rd_addr),
    .coef_addr(coef_addr),
    .mac_en(mac_en),
    .mac_clear(mac_clear),
    .acc_capture(acc_capture),
    .busy(busy)
`ifdef FIR_SEQ_PERF_EN
    ,
    .sample_count(sample_count),
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs t cycles after acceptance of a sample written at w,
  // with the result stalled s cycles in HOLD.
  function automatic obs_t model(int t, int w, int s);
    obs_t o;
    int last;
    o = '0;
    last = HS + s;
    o.wp = AW'(w + 1);
    if (t == 0) begin
      o.in_ready = 1'b1;
      o.we = 1'b1;
      o.wp = AW'(w);
    end else if (t > last) begin
      o.in_ready = 1'b1;
    end else begin
      o.busy = 1'b1;
      if (t <= N) begin
        o.mac_en = 1'b1;
        o.mac_clear = (t == 1);
        o.coef = AW'(t - 1);
        o.rd = AW'(w - (t - 1));
      end
      o.acc = (t == N + ML);
      o.ov = (t >= HS);
    end
    return o;
  endfunction

  function automatic obs_t observe(bit addr_ok);
    obs_t o;
    o.in_ready = in_ready;
    o.busy = busy;
    o.mac_en = mac_en;
    o.mac_clear = mac_clear;
    o.acc = acc_capture;
    o.ov = out_valid;
    o.we = sample_we;
    o.wp = wr_ptr;
    o.rd = addr_ok ? rd_addr : '0;
    o.coef = addr_ok ? coef_addr : '0;
    return o;
  endfunction

  // Entered at negedge+1 of an IDLE cycle with in_ready high; leaves at
  // negedge+1 of the following IDLE cycle.
  task automatic run_sample(input int s, input bit ivh);
    obs_t e;
    obs_t g;
    int w;
    w = wexp;
    for (int t = 0; t <= HS + s + 1; t++) begin
      if (t > 0) @(negedge clk);
      in_valid = (t == 0) || (ivh && t <= HS + s);
      out_ready = (t >= HS + s);
      #1;
      if (t == 0) accept_cyc = cyc;
      e = model(t, w, s);
      g = observe(e.mac_en);
      n_checks++;
      if (g !== e)
        $display("FAIL txn w=%0d t=%0d got=%h exp=%h", w, t, g, e);
      else
        n_pass++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    wexp = (wexp + 1) % N;
    stall_exp += s;
    samp_exp++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    wexp = 0;
    stall_exp = 0;
    samp_exp = 0;
  endtask

  task automatic test_reset();
    obs_t g;
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    g = observe(1'b1);
    n_checks++;
    if (g !== '0) $display("FAIL reset_vals got=%h exp=0", g);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || sample_we !== 1'b0)
      $display("FAIL rel_ready got=%b%b exp=00", in_ready, sample_we);
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || wr_ptr !== '0)
      $display("FAIL post_rel got=%b%b%h exp=100", in_ready, busy, wr_ptr);
    else n_pass++;
    wexp = 0;
  endtask

  task automatic test_single();
    run_sample(0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int prev;
    apply_reset();
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (wr_ptr !== AW'(i % N))
        $display("FAIL b2b_wp i=%0d got=%0d exp=%0d", i, wr_ptr, i % N);
      else n_pass++;
      run_sample(0, 1'b0);
      if (i > 0) begin
        n_checks++;
        if (accept_cyc - prev != N + ML + 2)
          $display("FAIL b2b_period got=%0d exp=%0d",
                   accept_cyc - prev, N + ML + 2);
        else n_pass++;
      end
      prev = accept_cyc;
    end
  endtask

  task automatic test_hold_stall();
    apply_reset();
    run_sample(10, 1'b0);
`ifdef FIR_SEQ_PERF_EN
    n_checks++;
    if (stall_count !== 16'd10 || sample_count !== 16'd1)
      $display("FAIL perf_stall got=%0d/%0d exp=10/1",
               stall_count, sample_count);
    else n_pass++;
`endif
  endtask

  task automatic test_ignore_in_valid();
    run_sample(2, 1'b1);
    run_sample(0, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    obs_t g;
    in_valid = 1'b1;
    #1;
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      #1;
    end
    n_checks++;
    if (mac_en !== 1'b1 || coef_addr !== AW'(2))
      $display("FAIL mid_run got=%b%h exp=1 2", mac_en, coef_addr);
    else n_pass++;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    g = observe(1'b1);
    n_checks++;
    if (g !== '0) $display("FAIL async_rst got=%h exp=0", g);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    wexp = 0;
    stall_exp = 0;
    samp_exp = 0;
    n_checks++;
    if (in_ready !== 1'b1 || wr_ptr !== '0)
      $display("FAIL rst_recover got=%b%h exp=1 0", in_ready, wr_ptr);
    else n_pass++;
    run_sample(1, 1'b0);
  endtask

  task automatic test_random();
    int gap;
    repeat (12) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || sample_we !== 1'b0)
          $display("FAIL idle_gap got=%b%b%b exp=100",
                   in_ready, busy, sample_we);
        else n_pass++;
        @(negedge clk);
        #1;
      end
      run_sample($urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end
`ifdef FIR_SEQ_PERF_EN
    n_checks++;
    if (stall_count !== 16'(stall_exp) || sample_count !== 16'(samp_exp))
      $display("FAIL perf_rand got=%0d/%0d exp=%0d/%0d",
               stall_count, sample_count, stall_exp, samp_exp);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold_stall();
    test_ignore_in_valid();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
